// File: rtl/isp_frame_loader.sv
// Host-side ISP loader: parses SYNC/COUNT/data/CHK frames into 32-bit words,
// writes them to the core's ISP port and starts the core after a good checksum.
// Optional macro ISP_TIMEOUT_EN enables an inter-byte timeout.
module isp_frame_loader #(
    parameter int         DATA_WIDTH     = 32,
    parameter int         ADDRESS_BITS   = 10,
    parameter int         PROG_BASE      = 0,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 65535
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [7:0]              byte_in,
    input  logic                    byte_valid,
    output logic                    byte_ready,
    output logic [ADDRESS_BITS-1:0] isp_address,
    output logic [DATA_WIDTH-1:0]   isp_data,
    output logic                    isp_write,
    output logic                    core_reset,
    output logic                    start,
    output logic [ADDRESS_BITS-1:0] prog_address,
    output logic                    load_done,
    output logic                    load_error
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CNT_LO = 3'd1,
        ST_CNT_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_CHECK  = 3'd4,
        ST_START  = 3'd5
    } state_t;

    localparam logic [ADDRESS_BITS-1:0] BASE_ADDR = ADDRESS_BITS'(PROG_BASE);

    if (DATA_WIDTH != 32) begin : g_bad_width
        $error("isp_frame_loader: DATA_WIDTH must be 32");
    end
    if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 65535)) begin : g_bad_timeout
        $error("isp_frame_loader: TIMEOUT_CYCLES must fit the 16-bit idle counter");
    end

    function automatic logic [7:0] chk_fold(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

    state_t                  state_r, state_s;
    logic [15:0]             count_r, count_s;
    logic [15:0]             word_cnt_r, word_cnt_s;
    logic [7:0]              chk_r, chk_s;
    logic [1:0]              idx_r, idx_s;
    logic [23:0]             word_buf_r, word_buf_s;
    logic [ADDRESS_BITS-1:0] isp_address_r, isp_address_s;
    logic [DATA_WIDTH-1:0]   isp_data_r, isp_data_s;
    logic                    isp_write_r, isp_write_s;
    logic                    core_reset_r, core_reset_s;
    logic                    start_r, start_s;
    logic                    load_done_r, load_done_s;
    logic                    load_error_r, load_error_s;
    logic                    accept_s;
`ifdef ISP_TIMEOUT_EN
    logic [15:0]             idle_cnt_r, idle_cnt_s;
`endif

    assign byte_ready   = (state_r != ST_START);
    assign accept_s     = byte_valid && byte_ready;
    assign isp_address  = isp_address_r;
    assign isp_data     = isp_data_r;
    assign isp_write    = isp_write_r;
    assign core_reset   = core_reset_r;
    assign start        = start_r;
    assign prog_address = BASE_ADDR;
    assign load_done    = load_done_r;
    assign load_error   = load_error_r;

    // Next-state and next-output decode for the frame parser.
    always_comb begin
        state_s      = state_r;
        count_s      = count_r;
        word_cnt_s   = word_cnt_r;
        chk_s        = chk_r;
        idx_s        = idx_r;
        word_buf_s   = word_buf_r;
        isp_data_s   = isp_data_r;
        isp_write_s  = 1'b0;
        start_s      = 1'b0;
        core_reset_s = core_reset_r;
        load_done_s  = load_done_r;
        load_error_s = load_error_r;
        // The address advances in the cycle after each write strobe.
        if (isp_write_r) begin
            isp_address_s = isp_address_r + ADDRESS_BITS'(1);
        end else begin
            isp_address_s = isp_address_r;
        end

        case (state_r)
            ST_IDLE: begin
                if (accept_s && (byte_in == SYNC_BYTE)) begin
                    core_reset_s  = 1'b1;
                    load_done_s   = 1'b0;
                    load_error_s  = 1'b0;
                    chk_s         = 8'h00;
                    idx_s         = 2'd0;
                    word_cnt_s    = 16'h0000;
                    isp_address_s = BASE_ADDR;
                    state_s       = ST_CNT_LO;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CNT_LO: begin
                if (accept_s) begin
                    count_s = {count_r[15:8], byte_in};
                    chk_s   = chk_fold(chk_r, byte_in);
                    state_s = ST_CNT_HI;
                end else begin
                    state_s = ST_CNT_LO;
                end
            end
            ST_CNT_HI: begin
                if (accept_s) begin
                    count_s = {byte_in, count_r[7:0]};
                    chk_s   = chk_fold(chk_r, byte_in);
                    if ({byte_in, count_r[7:0]} == 16'h0000) begin
                        state_s = ST_CHECK;
                    end else begin
                        state_s = ST_DATA;
                    end
                end else begin
                    state_s = ST_CNT_HI;
                end
            end
            ST_DATA: begin
                if (accept_s) begin
                    chk_s = chk_fold(chk_r, byte_in);
                    if (idx_r == 2'd3) begin
                        isp_data_s  = DATA_WIDTH'({byte_in, word_buf_r});
                        isp_write_s = 1'b1;
                        idx_s       = 2'd0;
                        word_cnt_s  = word_cnt_r + 16'd1;
                        if (word_cnt_s == count_r) begin
                            state_s = ST_CHECK;
                        end else begin
                            state_s = ST_DATA;
                        end
                    end else begin
                        case (idx_r)
                            2'd0:    word_buf_s[7:0]   = byte_in;
                            2'd1:    word_buf_s[15:8]  = byte_in;
                            2'd2:    word_buf_s[23:16] = byte_in;
                            default: word_buf_s        = word_buf_r;
                        endcase
                        idx_s = idx_r + 2'd1;
                    end
                end else begin
                    state_s = ST_DATA;
                end
            end
            ST_CHECK: begin
                if (accept_s) begin
                    if (byte_in == chk_r) begin
                        core_reset_s = 1'b0;
                        state_s      = ST_START;
                    end else begin
                        load_error_s = 1'b1;
                        state_s      = ST_IDLE;
                    end
                end else begin
                    state_s = ST_CHECK;
                end
            end
            ST_START: begin
                start_s     = 1'b1;
                load_done_s = 1'b1;
                state_s     = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

`ifdef ISP_TIMEOUT_EN
        // A silent host aborts the frame but keeps the core held in reset.
        if ((state_r == ST_IDLE) || (state_r == ST_START) || accept_s) begin
            idle_cnt_s = 16'h0000;
        end else if (idle_cnt_r == 16'(TIMEOUT_CYCLES)) begin
            idle_cnt_s   = 16'h0000;
            load_error_s = 1'b1;
            state_s      = ST_IDLE;
        end else begin
            idle_cnt_s = idle_cnt_r + 16'd1;
        end
`endif
    end

    // State and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r       <= ST_IDLE;
            count_r       <= 16'h0000;
            word_cnt_r    <= 16'h0000;
            chk_r         <= 8'h00;
            idx_r         <= 2'd0;
            word_buf_r    <= 24'h000000;
            isp_address_r <= BASE_ADDR;
            isp_data_r    <= '0;
            isp_write_r   <= 1'b0;
            core_reset_r  <= 1'b0;
            start_r       <= 1'b0;
            load_done_r   <= 1'b0;
            load_error_r  <= 1'b0;
`ifdef ISP_TIMEOUT_EN
            idle_cnt_r    <= 16'h0000;
`endif
        end else begin
            state_r       <= state_s;
            count_r       <= count_s;
            word_cnt_r    <= word_cnt_s;
            chk_r         <= chk_s;
            idx_r         <= idx_s;
            word_buf_r    <= word_buf_s;
            isp_address_r <= isp_address_s;
            isp_data_r    <= isp_data_s;
            isp_write_r   <= isp_write_s;
            core_reset_r  <= core_reset_s;
            start_r       <= start_s;
            load_done_r   <= load_done_s;
            load_error_r  <= load_error_s;
`ifdef ISP_TIMEOUT_EN
            idle_cnt_r    <= idle_cnt_s;
`endif
        end
    end

endmodule

// File: tb/tb_isp_frame_loader.sv
// Randomized bench for isp_frame_loader: a byte-stream frame model predicts
// every output each cycle, plus literal checks on the reference frames.
module tb_isp_frame_loader;

    localparam logic [9:0] BASE = 10'd0;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  byte_in = 8'h00;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic [9:0]  isp_address;
    logic [31:0] isp_data;
    logic        isp_write;
    logic        core_reset;
    logic        start;
    logic [9:0]  prog_address;
    logic        load_done;
    logic        load_error;

    isp_frame_loader dut (
        .clock(clock), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .isp_address(isp_address), .isp_data(isp_data),
        .isp_write(isp_write), .core_reset(core_reset), .start(start),
        .prog_address(prog_address), .load_done(load_done), .load_error(load_error)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    // Model of expected outputs for the current cycle.
    logic [9:0]  e_addr;
    logic [31:0] e_data;
    logic        e_write, e_start, e_cr, e_done, e_err, e_ready;
    bit          in_frame, pend_start;
    int          pos, nbytes;
    logic [7:0]  fb[$];
    logic [41:0] wlog[$];
    int          starts;
    logic [7:0]  tx[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_outputs();
        check("byte_ready", 32'(byte_ready), 32'(e_ready));
        check("isp_address", 32'(isp_address), 32'(e_addr));
        check("isp_data", isp_data, e_data);
        check("isp_write", 32'(isp_write), 32'(e_write));
        check("core_reset", 32'(core_reset), 32'(e_cr));
        check("start", 32'(start), 32'(e_start));
        check("load_done", 32'(load_done), 32'(e_done));
        check("load_error", 32'(load_error), 32'(e_err));
        check("prog_address", 32'(prog_address), 32'(BASE));
        if (isp_write === 1'b1) wlog.push_back({isp_address, isp_data});
        if (start === 1'b1) starts++;
    endtask

    task automatic model_reset();
        e_addr = BASE; e_data = 32'h0; e_write = 1'b0; e_start = 1'b0;
        e_cr = 1'b0; e_done = 1'b0; e_err = 1'b0; e_ready = 1'b1;
        in_frame = 1'b0; pend_start = 1'b0; pos = 0; nbytes = 0;
        fb.delete();
    endtask

    // Advance the model across one rising edge, given whether a byte was taken.
    task automatic model_step(input bit acc, input logic [7:0] b);
        logic [7:0] x;
        if (e_write) e_addr = e_addr + 10'd1;
        e_write = 1'b0;
        e_start = 1'b0;
        if (pend_start) begin
            e_start = 1'b1; e_done = 1'b1; pend_start = 1'b0; e_ready = 1'b1;
        end
        if (acc) begin
            if (!in_frame) begin
                if (b == 8'hA5) begin
                    in_frame = 1'b1; pos = 1; fb.delete();
                    e_cr = 1'b1; e_done = 1'b0; e_err = 1'b0; e_addr = BASE;
                end
            end else begin
                if (pos <= 2) begin
                    fb.push_back(b);
                    if (pos == 2) nbytes = 4 * int'({fb[1], fb[0]});
                end else if ((pos - 3) < nbytes) begin
                    fb.push_back(b);
                    if (((pos - 3) % 4) == 3) begin
                        e_write = 1'b1;
                        e_data  = {b, fb[pos-2], fb[pos-3], fb[pos-4]};
                    end
                end else begin
                    x = 8'h00;
                    foreach (fb[i]) x = x ^ fb[i];
                    if (x == b) begin
                        e_cr = 1'b0; pend_start = 1'b1; e_ready = 1'b0;
                    end else begin
                        e_err = 1'b1;
                    end
                    in_frame = 1'b0;
                end
                pos++;
            end
        end
    endtask

    task automatic step(input logic v, input logic [7:0] b, output bit acc);
        @(negedge clock);
        compare_outputs();
        byte_valid = v;
        byte_in    = b;
        acc        = v && e_ready;
        model_step(acc, b);
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, acc);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit acc;
        int tries;
        for (int i = 0; i < gap; i++) step(1'b0, 8'h00, acc);
        acc = 1'b0;
        tries = 0;
        while (!acc && tries < 8) begin
            step(1'b1, b, acc);
            tries++;
        end
        check("byte_accept", 32'(acc), 32'd1);
    endtask

    // gmode < 0 selects a random 0..2 cycle gap before each byte.
    task automatic send_tx(input int gmode);
        foreach (tx[i]) send_byte(tx[i], (gmode < 0) ? int'($urandom_range(0, 2)) : gmode);
    endtask

    task automatic build_frame(input int cnt, input bit bad);
        logic [15:0] c;
        logic [31:0] w;
        logic [7:0]  x;
        c = 16'(cnt);
        tx.delete();
        tx.push_back(8'hA5);
        tx.push_back(c[7:0]);
        tx.push_back(c[15:8]);
        x = c[7:0] ^ c[15:8];
        for (int i = 0; i < cnt; i++) begin
            w = $urandom();
            if ($urandom_range(0, 7) == 0) w[7:0] = 8'hA5;
            for (int k = 0; k < 4; k++) begin
                tx.push_back(w[8*k +: 8]);
                x = x ^ w[8*k +: 8];
            end
        end
        tx.push_back(bad ? (x ^ 8'h01) : x);
    endtask

    task automatic do_reset();
        @(negedge clock);
        byte_valid = 1'b0;
        reset = 1'b0;
        #1;
        model_reset();
        compare_outputs();
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic check_ref_writes(input string tag);
        check({tag, "_nw"}, 32'(wlog.size()), 32'd2);
        check({tag, "_a0"}, 32'(wlog[0][41:32]), 32'd0);
        check({tag, "_d0"}, wlog[0][31:0], 32'h00000013);
        check({tag, "_a1"}, 32'(wlog[1][41:32]), 32'd1);
        check({tag, "_d1"}, wlog[1][31:0], 32'h12345678);
    endtask

    initial begin
        model_reset();
        do_reset();
        idle(3);

        // Reference frame with good checksum.
        wlog.delete(); starts = 0;
        tx = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h19};
        send_tx(0);
        idle(4);
        check_ref_writes("ref");
        check("ref_starts", 32'(starts), 32'd1);
        check("ref_done", 32'(load_done), 32'd1);
        check("ref_err", 32'(load_error), 32'd0);
        check("ref_cr", 32'(core_reset), 32'd0);

        // Same frame with a corrupt checksum.
        wlog.delete(); starts = 0;
        tx[11] = 8'h18;
        send_tx(0);
        idle(4);
        check_ref_writes("bad");
        check("bad_starts", 32'(starts), 32'd0);
        check("bad_err", 32'(load_error), 32'd1);
        check("bad_cr", 32'(core_reset), 32'd1);
        check("bad_done", 32'(load_done), 32'd0);

        // Zero-count frame.
        wlog.delete(); starts = 0;
        tx = '{8'hA5, 8'h00, 8'h00, 8'h00};
        send_tx(0);
        idle(4);
        check("zero_nw", 32'(wlog.size()), 32'd0);
        check("zero_starts", 32'(starts), 32'd1);
        check("zero_done", 32'(load_done), 32'd1);

        // Junk in IDLE then the reference frame, one byte every third cycle.
        wlog.delete(); starts = 0;
        tx = '{8'h13, 8'h42, 8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
               8'h78, 8'h56, 8'h34, 8'h12, 8'h19};
        send_tx(2);
        idle(4);
        check_ref_writes("gap");
        check("gap_starts", 32'(starts), 32'd1);

        // Reset after six data bytes, then reload from the base address.
        tx = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        send_tx(0);
        idle(1);
        do_reset();
        check("rst_cr", 32'(core_reset), 32'd0);
        check("rst_addr", 32'(isp_address), 32'(BASE));
        wlog.delete(); starts = 0;
        tx = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h19};
        send_tx(0);
        idle(4);
        check_ref_writes("rld");

        // Randomized frames with junk, gaps and occasional bad checksums.
        for (int f = 0; f < 30; f++) begin
            if ($urandom_range(0, 3) == 0) begin
                tx = '{8'h00};
                tx[0] = 8'(($urandom_range(0, 253) + 8'hA6));
                send_tx(-1);
            end
            build_frame(int'($urandom_range(0, 5)), ($urandom_range(0, 3) == 0));
            send_tx(-1);
            idle(int'($urandom_range(0, 3)));
        end
        idle(3);

        // Long frame so the word address wraps past the top of the space.
        wlog.delete();
        build_frame(1030, 1'b0);
        send_tx(0);
        idle(4);
        check("wrap_nw", 32'(wlog.size()), 32'd1030);
        check("wrap_a1023", 32'(wlog[1023][41:32]), 32'd1023);
        check("wrap_a1024", 32'(wlog[1024][41:32]), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/isp_frame_loader.md
Name: isp_frame_loader

Overview:
Initiator side of the core's in-system programmer interface. It accepts a framed byte stream from a host link (for example a UART receiver) and assembles it into 32-bit instruction words. It writes those words through isp_address/isp_data/isp_write and holds the core in reset while loading. After a frame passes its checksum it releases the core and pulses start with prog_address. It sits between the host link and the core, one instance per core.

Parameters:
DATA_WIDTH, 32, ISP data word width; must be 32.
ADDRESS_BITS, 10, width of isp_address and prog_address.
PROG_BASE, 0, first word address written; also driven on prog_address.
SYNC_BYTE, 8'hA5, frame start marker.
TIMEOUT_CYCLES, 65535, inter-byte timeout; used only with ISP_TIMEOUT_EN.

Ports:
clock  input  1  system clock.
reset  input  1  reset; one clock; reset is asynchronous and active-low.
byte_in  input  8  host byte.
byte_valid  input  1  byte_in valid.
byte_ready  output  1  loader can accept byte_in this cycle.
isp_address  output  ADDRESS_BITS  word address to core ISP.
isp_data  output  DATA_WIDTH  instruction word to core ISP.
isp_write  output  1  one-cycle ISP write strobe.
core_reset  output  1  active-high reset to core; high while loading.
start  output  1  one-cycle core start pulse.
prog_address  output  ADDRESS_BITS  constant PROG_BASE.
load_done  output  1  sticky: last frame loaded and started.
load_error  output  1  sticky: last frame failed its checksum or timed out.

Behaviour:
- Frame format: SYNC_BYTE, COUNT_LO, COUNT_HI, then 4*COUNT data bytes (each word little-endian), then CHK.
- CHK is the XOR of COUNT_LO, COUNT_HI and all data bytes.
- A byte is accepted on any rising clock edge with byte_valid && byte_ready.
- byte_ready is 1 in every state except START.
- Reset values: isp_address=PROG_BASE, isp_data=0, isp_write=0, core_reset=0, start=0, load_done=0, load_error=0. State is IDLE.
- Reset asserted mid-frame discards the partial frame. No further isp_write occurs. Words already written stay in the core's memory.
- IDLE:
  - Non-sync bytes are discarded.
  - SYNC_BYTE: core_reset=1 from the next cycle; load_done and load_error clear; checksum, byte index and word counter clear; isp_address=PROG_BASE; go to CNT_LO.
- CNT_LO → CNT_HI: latch the low count byte and XOR it into the checksum.
- CNT_HI: latch the high count byte and XOR it in. If COUNT==0 go to CHECK, else go to DATA.
- DATA:
  - Shift each byte into the word buffer at bit position 8*index, and XOR it into the checksum.
  - On the 4th byte: isp_data=assembled word and isp_write=1 for exactly the next cycle, at the current isp_address.
  - isp_address increments by 1 in the cycle after the strobe and wraps modulo 2^ADDRESS_BITS.
  - When the word counter equals COUNT, go to CHECK.
- CHECK, on the checksum byte:
  - Match: core_reset falls the next cycle; go to START.
  - Mismatch: load_error=1, core_reset stays 1, return to IDLE.
- START: start=1 for one cycle and load_done=1, then return to IDLE. Latency from CHK acceptance to start is 2 cycles.
- A SYNC_BYTE received inside a frame is treated as data. There is no resynchronisation until IDLE.
- isp_write and start are never asserted in the same cycle.
- isp_write never asserts while core_reset=0.

Optional Feature:
ISP_TIMEOUT_EN
- Defined: a 16-bit idle counter runs in every state except IDLE and START. It clears on each accepted byte. When it reaches TIMEOUT_CYCLES the loader sets load_error=1, keeps core_reset=1 and returns to IDLE.
- Undefined: there is no counter, and the loader waits indefinitely for the next byte.

Test Plan:
- Valid frame: A5 02 00 13 00 00 00 78 56 34 12 19 → two isp_write pulses: addr 0 / 0x00000013, then addr 1 / 0x12345678. core_reset falls, start pulses 2 cycles after CHK, load_done=1, load_error=0.
- Same frame with CHK=0x18 → both words written, load_error=1, core_reset stays 1, no start pulse.
- Zero count: A5 00 00 00 → no isp_write, start pulses, load_done=1.
- Bytes 0x13 0x42 in IDLE followed by a valid frame → leading bytes ignored and the frame loads normally. Gapped byte_valid (1 of every 3 cycles) produces identical writes.
- Reset pulled low after 6 data bytes → all outputs return to reset values immediately. The next valid frame loads from PROG_BASE.
- With ISP_TIMEOUT_EN and TIMEOUT_CYCLES=100: A5 01 00 AA then silence → load_error=1 after 100 idle cycles, state IDLE, core_reset=1.
